// File: rtl/fsk_pkg.sv
// Shared types and helpers for the FSK bit-level back end.
package fsk_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  localparam logic [15:0] SYNC_WORD_DEF = 16'h2DD4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fsk_slicer_timing.sv
// Hysteresis slicer plus resettable phase counter; emits a registered
// mid-bit strobe together with the sliced bit.
module fsk_slicer_timing #(
  parameter int DW   = 12,
  parameter int SPB  = 16,
  parameter int HYST = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic                 sbit,
  output logic                 bit_strobe
);

  localparam int PW = $clog2(SPB);
  localparam logic signed [DW:0] HYST_P = (DW+1)'(HYST);
  localparam logic signed [DW:0] HYST_N = -HYST_P;

  logic signed [DW:0] din_x;
  logic               bit_q, bit_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic               strobe_q, strobe_d;

  // One extra bit so that negating the threshold and the most negative
  // sample can never wrap.
  assign din_x = {din[DW-1], din};

  function automatic logic slice(input logic signed [DW:0] x, input logic prev);
    if (x > HYST_P) begin
      return 1'b1;
    end else if (x < HYST_N) begin
      return 1'b0;
    end
    return prev;
  endfunction

  always_comb begin
    bit_d    = bit_q;
    phase_d  = phase_q;
    strobe_d = 1'b0;
    if (din_valid) begin
      bit_d = slice(din_x, bit_q);
      if (bit_d != bit_q) begin
        phase_d = '0;
      end else if (phase_q == PW'(SPB - 1)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
      strobe_d = (phase_d == PW'(SPB / 2));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q    <= 1'b0;
      phase_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      strobe_q <= strobe_d;
    end
  end

  assign sbit       = bit_q;
  assign bit_strobe = strobe_q;

endmodule

// File: rtl/fsk_bit_sync.sv
// FSK bit-level back end: sync-word hunt, payload byte assembly, squelch
// abort and a valid/ready byte stream with sticky overflow.
module fsk_bit_sync
  import fsk_pkg::*;
#(
  parameter int          DW           = 12,
  parameter int          SPB          = 16,
  parameter int          HYST         = 64,
  parameter logic [15:0] SYNC_WORD    = SYNC_WORD_DEF,
  parameter int          MAX_ERR      = 0,
  parameter int          FRAME_BYTES  = 4,
  parameter int          SQUELCH_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 sync_det,
  output logic                 lock,
  output logic                 frame_err,
  output logic                 overflow
);

  localparam int SQ_N = SQUELCH_BITS * SPB;
  localparam int SQW  = $clog2(SQ_N + 1);
  localparam logic signed [DW:0] HYST_P = (DW+1)'(HYST);
  localparam logic signed [DW:0] HYST_N = -HYST_P;

  logic               sbit, bit_strobe;
  logic signed [DW:0] din_x;
  logic               in_band;

  state_e         state_q, state_d;
  logic [15:0]    sync_q, sync_d, sync_shift;
  logic [6:0]     shreg_q, shreg_d;
  logic [7:0]     byte_val;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     byte_cnt_q, byte_cnt_d;
  logic [SQW-1:0] sq_cnt_q, sq_cnt_d;
  logic           sq_hit_q, sq_hit_d;
  logic [7:0]     out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic           sync_det_q, sync_det_d;
  logic           frame_err_q, frame_err_d;
  logic           overflow_q, overflow_d;

  logic sync_hit, abort, pay_strobe, byte_done, last_byte;

  fsk_slicer_timing #(
    .DW  (DW),
    .SPB (SPB),
    .HYST(HYST)
  ) u_slicer (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .sbit      (sbit),
    .bit_strobe(bit_strobe)
  );

  assign din_x   = {din[DW-1], din};
  assign in_band = (din_x <= HYST_P) && (din_x >= HYST_N);

  // The squelch hit is registered so it lines up with the strobe of the
  // same sample; an abort therefore beats a byte completing on that sample.
  assign sync_shift = {sync_q[14:0], sbit};
  assign sync_hit   = (state_q == HUNT) && bit_strobe &&
                      (popcount16(sync_shift ^ SYNC_WORD) <= 5'(MAX_ERR));
  assign abort      = (state_q == PAYLOAD) && sq_hit_q;
  assign pay_strobe = (state_q == PAYLOAD) && bit_strobe && !abort;
  assign byte_val   = {shreg_q, sbit};
  assign byte_done  = pay_strobe && (bit_cnt_q == 3'd7);
  assign last_byte  = byte_done && (byte_cnt_q == 8'(FRAME_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT:    if (sync_hit) state_d = PAYLOAD;
      PAYLOAD: if (abort || last_byte) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    sync_d      = sync_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    sq_cnt_d    = sq_cnt_q;
    sq_hit_d    = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    sync_det_d  = 1'b0;
    frame_err_d = 1'b0;
    overflow_d  = overflow_q;

    if ((state_q == HUNT) && bit_strobe) begin
      sync_d = sync_shift;
      if (sync_hit) begin
        sync_det_d = 1'b1;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
      end
    end

    if (abort) begin
      frame_err_d = 1'b1;
      sync_d      = '0;
      bit_cnt_d   = '0;
      shreg_d     = '0;
    end

    if (pay_strobe) begin
      shreg_d   = byte_val[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (byte_done) begin
      byte_cnt_d = byte_cnt_q + 8'd1;
      if (last_byte) begin
        sync_d = '0;
      end
      if (out_valid_q && !out_ready) begin
        overflow_d = 1'b1;
      end else begin
        out_data_d  = byte_val;
        out_last_d  = last_byte;
        out_valid_d = 1'b1;
      end
    end

    if (state_q != PAYLOAD) begin
      sq_cnt_d = '0;
    end else if (din_valid) begin
      if (!in_band) begin
        sq_cnt_d = '0;
      end else if (sq_cnt_q < SQW'(SQ_N)) begin
        sq_cnt_d = sq_cnt_q + 1'b1;
        sq_hit_d = (sq_cnt_q == SQW'(SQ_N - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      sq_cnt_q    <= '0;
      sq_hit_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sync_det_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      sq_cnt_q    <= sq_cnt_d;
      sq_hit_q    <= sq_hit_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      sync_det_q  <= sync_det_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign sync_det  = sync_det_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign lock      = (state_q == PAYLOAD);

endmodule

// File: tb/tb_fsk_bit_sync.sv
// Bench for fsk_bit_sync: frame table, randomized frames and hand-written
// backpressure / squelch / mid-frame reset sequences.
module tb_fsk_bit_sync;

  localparam int DW   = 12;
  localparam int SPB  = 16;
  localparam int HYST = 64;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] din = '0;
  logic                 din_valid = 1'b0;
  logic                 rdy0 = 1'b1;
  logic                 rdy1 = 1'b1;

  logic [7:0] od0, od1;
  logic ov0, ol0, sd0, lk0, fe0, of0;
  logic ov1, ol1, sd1, lk1, fe1, of1;

  always #5 clk = ~clk;

  fsk_bit_sync u0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .out_data(od0), .out_valid(ov0), .out_ready(rdy0), .out_last(ol0),
    .sync_det(sd0), .lock(lk0), .frame_err(fe0), .overflow(of0)
  );

  fsk_bit_sync #(.MAX_ERR(1)) u1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .out_data(od1), .out_valid(ov1), .out_ready(rdy1), .out_last(ol1),
    .sync_det(sd1), .lock(lk1), .frame_err(fe1), .overflow(of1)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] got0[$];
  logic [8:0] got1[$];
  int nsync0 = 0, nsync1 = 0, nferr0 = 0;
  bit seen_lock0 = 1'b0;

  // Scoreboard capture: a byte counts as delivered when the handshake is seen.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov0 && rdy0) got0.push_back({ol0, od0});
      if (ov1 && rdy1) got1.push_back({ol1, od1});
      if (sd0) nsync0++;
      if (sd1) nsync1++;
      if (fe0) nferr0++;
      if (lk0) seen_lock0 = 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    got0.delete();
    got1.delete();
    nsync0 = 0;
    nsync1 = 0;
    nferr0 = 0;
    seen_lock0 = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_sample(input int v, input int gap);
    @(posedge clk); #1;
    din = v[DW-1:0];
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  // Bits MSB first, SPB samples each; up to 'noise' in-band samples replace
  // the start of a bit wherever its level changes (delays the edge).
  task automatic send_bits(input logic [63:0] bits, input int n, input int pos,
                           input int neg, input int noise, input int gap);
    logic prev, b;
    int k, v;
    prev = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      b = bits[i];
      k = int'($urandom_range(noise, 0));
      for (int s = 0; s < SPB; s++) begin
        if (s < k && b != prev) v = int'($urandom_range(2 * HYST, 0)) - HYST;
        else v = b ? pos : neg;
        send_sample(v, int'($urandom_range(gap, 0)));
      end
      prev = b;
    end
  endtask

  task automatic check_frame(input string tag, input logic [31:0] pay);
    logic [8:0] g;
    check({tag, "_nsync"}, nsync0, 1);
    check({tag, "_nbytes"}, got0.size(), 4);
    for (int j = 0; j < 4; j++) begin
      g = (j < got0.size()) ? got0[j] : 9'h1FF;
      check({tag, "_data"}, g[7:0], pay[31 - 8 * j -: 8]);
      check({tag, "_last"}, g[8], (j == 3));
    end
    check({tag, "_lock_end"}, lk0, 0);
    check({tag, "_ovf"}, of0, 0);
  endtask

  typedef struct {
    logic [15:0] sw;
    logic [31:0] pay;
    int pos;
    int neg;
    int noise;
    int exp_sync;
    int exp_sync1;
  } row_t;

  row_t rows[6];

  initial begin
    logic [31:0] pay;
    logic [8:0]  g;
    int pos, neg;

    rows[0] = '{16'h2DD4, 32'h12345678,  500,  -500, 0, 1, 1};
    rows[1] = '{16'h2DD4, 32'h12345678,  500,  -500, 3, 1, 1};
    rows[2] = '{16'h2DD4, 32'hA5C30FF1,   65,   -65, 0, 1, 1};
    rows[3] = '{16'h2DD4, 32'h12345678, 2047, -2048, 2, 1, 1};
    rows[4] = '{16'h2DD5, 32'h12345678,  500,  -500, 0, 0, 1};
    rows[5] = '{16'h2DD4, 32'h12345678,   64,   -64, 0, 0, 0};

    do_reset();
    check("rst_valid", ov0, 0);
    check("rst_data", od0, 0);
    check("rst_last", ol0, 0);
    check("rst_sync", sd0, 0);
    check("rst_lock", lk0, 0);
    check("rst_ferr", fe0, 0);
    check("rst_ovf", of0, 0);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      clear_mon();
      send_bits({16'hAAAA, rows[r].sw, rows[r].pay}, 64, rows[r].pos, rows[r].neg,
                rows[r].noise, 0);
      repeat (20) @(posedge clk);
      if (rows[r].exp_sync != 0) begin
        check_frame($sformatf("row%0d", r), rows[r].pay);
        check($sformatf("row%0d_lock_seen", r), seen_lock0, 1);
      end else begin
        check($sformatf("row%0d_nsync", r), nsync0, 0);
        check($sformatf("row%0d_nbytes", r), got0.size(), 0);
        check($sformatf("row%0d_lock_seen", r), seen_lock0, 0);
      end
      check($sformatf("row%0d_u1_nsync", r), nsync1, rows[r].exp_sync1);
      check($sformatf("row%0d_u1_nbytes", r), got1.size(), 4 * rows[r].exp_sync1);
      if (rows[r].exp_sync1 != 0) begin
        g = (got1.size() > 0) ? got1[0] : 9'h1FF;
        check($sformatf("row%0d_u1_first", r), g, {1'b0, rows[r].pay[31:24]});
      end
    end

    do_reset();
    for (int f = 0; f < 5; f++) begin
      clear_mon();
      pay = $urandom;
      pos = int'($urandom_range(2047, HYST + 1));
      neg = -int'($urandom_range(2048, HYST + 1));
      send_bits({16'hAAAA, 16'h2DD4, pay}, 64, pos, neg, 3, 1);
      repeat (20) @(posedge clk);
      check_frame($sformatf("rnd%0d", f), pay);
      check($sformatf("rnd%0d_ferr", f), nferr0, 0);
    end

    // Backpressure: first byte held, second byte dropped, later ones too.
    do_reset();
    clear_mon();
    rdy0 = 1'b0;
    send_bits({40'h0, 16'hAAAA, 16'h2DD4, 8'h12}, 40, 500, -500, 0, 0);
    repeat (10) @(posedge clk);
    check("bp_valid1", ov0, 1);
    check("bp_data1", od0, 8'h12);
    check("bp_ovf1", of0, 0);
    send_bits({40'h0, 8'h34, 8'h56, 8'h78}, 24, 500, -500, 0, 0);
    repeat (10) @(posedge clk);
    check("bp_valid2", ov0, 1);
    check("bp_data2", od0, 8'h12);
    check("bp_last2", ol0, 0);
    check("bp_ovf2", of0, 1);
    check("bp_lock", lk0, 0);
    @(posedge clk); #1 rdy0 = 1'b1;
    repeat (25) @(posedge clk);
    check("bp_valid_drop", ov0, 0);
    check("bp_nbytes", got0.size(), 1);
    g = (got0.size() > 0) ? got0[0] : 9'h1FF;
    check("bp_byte", g, {1'b0, 8'h12});
    check("bp_ovf_sticky", of0, 1);

    // Squelch: 63 silent samples keep the frame, the 64th aborts it.
    do_reset();
    clear_mon();
    send_bits({40'h0, 16'hAAAA, 16'h2DD4, 8'h12}, 40, 500, -500, 0, 0);
    repeat (63) send_sample(0, 0);
    repeat (6) @(posedge clk);
    check("sq_ferr_63", nferr0, 0);
    check("sq_lock_63", lk0, 1);
    send_sample(0, 0);
    repeat (6) @(posedge clk);
    check("sq_ferr_64", nferr0, 1);
    check("sq_lock_64", lk0, 0);
    check("sq_nbytes", got0.size(), 1);
    g = (got0.size() > 0) ? got0[0] : 9'h1FF;
    check("sq_byte", g, {1'b0, 8'h12});
    clear_mon();
    send_bits({16'hAAAA, 16'h2DD4, 32'hCAFE0123}, 64, 500, -500, 0, 0);
    repeat (20) @(posedge clk);
    check_frame("sq_next", 32'hCAFE0123);

    // Reset in the middle of byte 3 while a byte is held.
    do_reset();
    clear_mon();
    rdy0 = 1'b0;
    send_bits({12'h0, 16'hAAAA, 16'h2DD4, 8'h12, 8'h34, 4'h5}, 52, 500, -500, 0, 0);
    repeat (4) @(posedge clk);
    check("mr_pre_valid", ov0, 1);
    check("mr_pre_ovf", of0, 1);
    check("mr_pre_lock", lk0, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mr_valid", ov0, 0);
    check("mr_data", od0, 0);
    check("mr_last", ol0, 0);
    check("mr_sync", sd0, 0);
    check("mr_lock", lk0, 0);
    check("mr_ferr", fe0, 0);
    check("mr_ovf", of0, 0);
    rdy0 = 1'b1;
    clear_mon();
    send_bits({16'hAAAA, 16'h2DD4, 32'h12345678}, 64, 500, -500, 0, 0);
    repeat (20) @(posedge clk);
    check_frame("mr_next", 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
